// File: rtl/mips_pkg.sv
// Shared definitions for the register-file access controller.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Requester indices within the packed [r1|r0] request fields.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_RESP  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant, only while enabled.
  always_comb begin
    grant = '0;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates core and debug/loader requesters onto a single register-file port.
module regfile_access_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_rs,
  input  logic [2*ADDR_W-1:0] req_rt,
  input  logic [2*ADDR_W-1:0] req_rd,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata1,
  output logic [DATA_W-1:0]   rsp_rdata2,
  output logic [1:0]          wr_done,
  output logic [ADDR_W-1:0]   rf_read_reg1,
  output logic [ADDR_W-1:0]   rf_read_reg2,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                rf_reg_write,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2,
  output logic                busy
);

  state_t            state;
  logic              last_grant;
  logic              arb_en;
  logic [1:0]        grant;
  logic              gnt_idx;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_rs;
  logic [ADDR_W-1:0] sel_rt;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_wdata;

  // rst_n gates arbitration so req_ready is held low throughout reset.
  assign arb_en = (state == ST_IDLE) && rst_n;

  rr_arbiter2 u_arb (
    .valid  (req_valid),
    .enable (arb_en),
    .last   (last_grant),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign busy      = (state != ST_IDLE);
  assign gnt_idx   = grant[1];

  // Payload mux for the granted requester.
  always_comb begin
    sel_write = gnt_idx ? req_write[1] : req_write[0];
    sel_rs    = gnt_idx ? req_rs[2*ADDR_W-1:ADDR_W] : req_rs[ADDR_W-1:0];
    sel_rt    = gnt_idx ? req_rt[2*ADDR_W-1:ADDR_W] : req_rt[ADDR_W-1:0];
    sel_rd    = gnt_idx ? req_rd[2*ADDR_W-1:ADDR_W] : req_rd[ADDR_W-1:0];
    sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Access FSM with registered register-file and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= REQ_DBG;
      rsp_valid     <= '0;
      rsp_rdata1    <= '0;
      rsp_rdata2    <= '0;
      wr_done       <= '0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else begin
      rsp_valid    <= '0;
      wr_done      <= '0;
      rf_reg_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            last_grant <= gnt_idx;
            if (sel_write) begin
              // Write strobe and completion are launched together so both
              // appear in the single WRITE cycle.
              rf_write_reg  <= sel_rd;
              rf_write_data <= sel_wdata;
              rf_reg_write  <= (sel_rd != '0);
              wr_done       <= grant;
              state         <= ST_WRITE;
            end else begin
              rf_read_reg1 <= sel_rs;
              rf_read_reg2 <= sel_rt;
              state        <= ST_READ;
            end
          end
        end
        ST_READ: begin
          rsp_valid[last_grant] <= 1'b1;
          rsp_rdata1 <= (rf_read_reg1 == '0) ? '0 : rf_read_data1;
          rsp_rdata2 <= (rf_read_reg2 == '0) ? '0 : rf_read_data2;
          state      <= ST_RESP;
        end
        ST_RESP:  state <= ST_IDLE;
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
